downsizing: RTL and testbench
=============================

// Module: downsizing
// PURPOSE
//  AXI-Stream width halver: takes 2*W-bit beats and emits them as two W-bit beats.
//  Sits directly downstream of upsizing and restores its original beat stream.
//  Upper half [2W-1:W] goes out first, then lower half [W-1:0], matching upsizing packing.
//  Optional half-beat and packet-end marking; full backpressure on both sides.
// PARAMETERS
//  W   40   output beat width in bits; input beat is 2*W
// PORTS
//  aclk        in   1     clock; all logic on rising edge
//  aresetn     in   1     asynchronous active-low reset
//  in_tdata    in   2*W   wide beat; [2W-1:W] is first narrow beat, [W-1:0] second
//  in_tvalid   in   1     wide beat valid
//  in_thalf    in   1     1 = only upper half meaningful; lower half dropped
//  in_tlast    in   1     wide beat ends a packet
//  in_tready   out  1     block can accept a wide beat this cycle
//  out_tdata   out  W     narrow beat
//  out_tvalid  out  1     narrow beat valid
//  out_tlast   out  1     narrow beat is the last of its packet
//  out_tready  in   1     downstream accepts narrow beat
// BEHAVIOUR
//  Handshake: transfer when tvalid & tready on a rising aclk edge; AXI-S rules:
//   out_tvalid, once high, stays high and out_tdata/out_tlast stay stable until accepted.
//  Reset (aresetn low, async): state=EMPTY, out_tvalid=0, out_tlast=0, out_tdata=0,
//   in_tready=0 while aresetn low; in_tready=1 from first edge after release.
//   Reset mid-packet discards held word; no partial beat after release.
//  Storage: one 2W data register + thalf + tlast flags.
//  States:
//   EMPTY: out_tvalid=0, in_tready=1. Accept -> load regs, go HIGH.
//   HIGH:  out_tdata=reg[2W-1:W], out_tvalid=1, in_tready=0,
//          out_tlast = reg_tlast & reg_thalf.
//          On out accept: reg_thalf ? (LOW-equivalent exit, see below) : go LOW.
//   LOW:   out_tdata=reg[W-1:0], out_tvalid=1, out_tlast=reg_tlast.
//          in_tready = out_tready (combinational; only such path).
//  Exit of last narrow beat (LOW accept, or HIGH accept with reg_thalf=1):
//   in_tvalid & in_tready -> load new word, go HIGH (no bubble);
//   else go EMPTY. in_tready in HIGH equals out_tready when reg_thalf=1.
//  Throughput: 1 wide beat per 2 cycles full-width; 1 per cycle if every beat thalf=1.
//  Latency: accepted wide beat's upper half on out_tdata the next cycle.
//  Input signals ignored while in_tvalid=0; data never changes while out_tvalid & !out_tready.
//  out_tready low indefinitely: state holds, in_tready=0 (except EMPTY), no loss.
//  Simultaneous last-beat accept and new input accept: both occur same edge, no drop/dup.
//  in_thalf=1 with in_tlast=0 is legal (mid-packet odd beat); out_tlast=0.
//  Assertions: out_tdata/out_tlast stable while out_tvalid & !out_tready; no X on
//   out_tvalid after reset.
// TESTING (W=40, ASCII data, out_tready=1 unless noted)
//  1 back-to-back: "ABCDEFGHIJ","KLMNOPQRST","UVWXYZabcd" valid every cycle ->
//    out "ABCDE","FGHIJ","KLMNO",...,"Zabcd" on consecutive cycles, in_tready 1,0,1,0.
//  2 gaps: same words with in_tvalid idle 3 cycles between -> same narrow order,
//    out_tvalid low in idle gaps, first narrow beat 1 cycle after each accept.
//  3 half/last: "ABCDE....." thalf=1 tlast=1 then "FGHIJKLMNO" tlast=1 ->
//    out "ABCDE"(last=1), "FGHIJ"(0), "KLMNO"(1); lower half of first word never seen.
//  4 backpressure: out_tready 8 high/8 low, then toggling each cycle, then $urandom,
//    3 packets of 3 wide words -> scoreboard matches exact narrow sequence, no drop/dup,
//    stability assertion never fires.
//  5 reset mid-op: assert aresetn=0 while in LOW with out_tready=0 ->
//    out_tvalid drops to 0 immediately (async), in_tready=0; after release next
//    word "ABCDEFGHIJ" yields only "ABCDE","FGHIJ".
//  6 chain: upsizing(W=40) -> downsizing(W=40), random valid/ready both ends, 200 beats ->
//    output stream identical to input stream; no hang within 1000 cycles.

Source files
------------

// File: rtl/downsizing_if.sv
// AXI-Stream link used on both sides of the width halver.
// thalf only carries meaning on the wide side; it is tied low on the narrow side.
interface downsizing_if #(
    parameter int unsigned DW = 80
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          thalf;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output thalf,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  thalf,
        output tready
    );
endinterface

// File: rtl/downsizing.sv
// AXI-Stream width halver: each 2*W-bit beat leaves as its upper half, then its lower half.
// A wide beat flagged thalf emits only the upper half.
module downsizing #(
    parameter int unsigned W = 40
) (
    input  logic         aclk,
    input  logic         aresetn,
    downsizing_if.slave  in_bus,
    downsizing_if.master out_bus
);
    typedef enum logic [1:0] {
        EMPTY,
        HIGH,
        LOW
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2*W-1:0] data_q;
    logic           half_q;
    logic           last_q;
    logic           rst_done_q;

    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           load;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= EMPTY;
            data_q     <= '0;
            half_q     <= 1'b0;
            last_q     <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            rst_done_q <= 1'b1;
            if (load) begin
                data_q <= in_bus.tdata;
                half_q <= in_bus.thalf;
                last_q <= in_bus.tlast;
            end
        end
    end

    // The final narrow beat of a word may be replaced by the next word on the same edge.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        state_nxt = state;
        case (state)
            EMPTY: begin
                in_ready = rst_done_q;
                if (in_bus.tvalid && in_ready) state_nxt = HIGH;
            end
            HIGH: begin
                out_valid = 1'b1;
                out_data  = data_q[2*W-1:W];
                out_last  = last_q & half_q;
                in_ready  = half_q & out_bus.tready;
                if (out_bus.tready) begin
                    if (!half_q)            state_nxt = LOW;
                    else if (in_bus.tvalid) state_nxt = HIGH;
                    else                    state_nxt = EMPTY;
                end
            end
            LOW: begin
                out_valid = 1'b1;
                out_data  = data_q[W-1:0];
                out_last  = last_q;
                in_ready  = out_bus.tready;
                if (out_bus.tready) state_nxt = in_bus.tvalid ? HIGH : EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
        load = in_bus.tvalid & in_ready;
    end

    assign in_bus.tready  = in_ready;
    assign out_bus.tvalid = out_valid;
    assign out_bus.tdata  = out_data;
    assign out_bus.tlast  = out_last;
    assign out_bus.thalf  = 1'b0;

    a_out_stable: assert property (@(posedge aclk) disable iff (!aresetn)
        out_bus.tvalid && !out_bus.tready |=> out_bus.tvalid && $stable(out_bus.tdata) && $stable(out_bus.tlast));

    a_valid_known: assert property (@(posedge aclk) disable iff (!aresetn)
        !$isunknown(out_bus.tvalid));
endmodule

// File: tb/tb_downsizing.sv
// Bench for downsizing (W=40): cycle-exact vector table, async reset mid-word,
// and a scoreboarded stream under patterned and random backpressure.
module tb_downsizing;
    localparam int unsigned W = 40;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    downsizing_if #(.DW(2*W)) in_bus ();
    downsizing_if #(.DW(W))   out_bus ();

    downsizing #(.W(W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .in_bus  (in_bus),
        .out_bus (out_bus)
    );

    typedef struct {
        logic           vld;
        logic [2*W-1:0] data;
        logic           half;
        logic           last;
        logic           ordy;
        logic           exp_irdy;
        logic           exp_ovld;
        logic [W-1:0]   exp_odata;
        logic           exp_olast;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [2*W-1:0] d, input logic h, input logic l,
                                input logic ordy, input logic eir, input logic eov,
                                input logic [W-1:0] eod, input logic eol);
        vec_t v;
        v.vld = vld; v.data = d; v.half = h; v.last = l; v.ordy = ordy;
        v.exp_irdy = eir; v.exp_ovld = eov; v.exp_odata = eod; v.exp_olast = eol;
        return v;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           vecs[$];
        logic [2*W-1:0] wd[$];
        logic           wh[$];
        logic           wl[$];
        logic [W:0]     expq[$];
        logic [95:0]    rnd;
        logic           acc;
        int             idx;
        int             cyc;
        string          nm;

        // back-to-back full words
        vecs.push_back(mk(1, "ABCDEFGHIJ", 0, 0, 1, 1, 0, 0,       0));
        vecs.push_back(mk(1, "KLMNOPQRST", 0, 0, 1, 0, 1, "ABCDE", 0));
        vecs.push_back(mk(1, "KLMNOPQRST", 0, 0, 1, 1, 1, "FGHIJ", 0));
        vecs.push_back(mk(1, "UVWXYZabcd", 0, 0, 1, 0, 1, "KLMNO", 0));
        vecs.push_back(mk(1, "UVWXYZabcd", 0, 0, 1, 1, 1, "PQRST", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 0, 1, "UVWXY", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 1, 1, "Zabcd", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 1, 0, 0,       0));
        // half word ending a packet, followed by a full last word
        vecs.push_back(mk(1, "ABCDE.....", 1, 1, 1, 1, 0, 0,       0));
        vecs.push_back(mk(1, "FGHIJKLMNO", 0, 1, 1, 1, 1, "ABCDE", 1));
        vecs.push_back(mk(0, 0,            0, 0, 1, 0, 1, "FGHIJ", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 1, 1, "KLMNO", 1));
        vecs.push_back(mk(0, 0,            0, 0, 1, 1, 0, 0,       0));
        // stalls in HIGH and LOW
        vecs.push_back(mk(1, "ABCDEFGHIJ", 0, 0, 0, 1, 0, 0,       0));
        vecs.push_back(mk(1, "KLMNOPQRST", 0, 0, 0, 0, 1, "ABCDE", 0));
        vecs.push_back(mk(1, "KLMNOPQRST", 0, 0, 1, 0, 1, "ABCDE", 0));
        vecs.push_back(mk(1, "KLMNOPQRST", 0, 0, 0, 0, 1, "FGHIJ", 0));
        vecs.push_back(mk(1, "KLMNOPQRST", 0, 0, 1, 1, 1, "FGHIJ", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 0, 1, "KLMNO", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 1, 1, "PQRST", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 1, 0, 0,       0));
        // mid-packet half word stalled, then replaced on the same edge
        vecs.push_back(mk(1, "VWXYZ.....", 1, 0, 0, 1, 0, 0,       0));
        vecs.push_back(mk(1, "abcdefghij", 0, 0, 0, 0, 1, "VWXYZ", 0));
        vecs.push_back(mk(1, "abcdefghij", 0, 0, 1, 1, 1, "VWXYZ", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 0, 1, "abcde", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 1, 1, "fghij", 0));
        vecs.push_back(mk(0, 0,            0, 0, 1, 1, 0, 0,       0));

        aresetn        = 1'b0;
        in_bus.tvalid  = 1'b0;
        in_bus.tdata   = '0;
        in_bus.thalf   = 1'b0;
        in_bus.tlast   = 1'b0;
        out_bus.tready = 1'b1;

        repeat (3) @(negedge aclk);
        #1;
        check("rst_in_tready",   in_bus.tready,  0);
        check("rst_out_tvalid",  out_bus.tvalid, 0);
        check("rst_out_tdata",   out_bus.tdata,  0);
        check("rst_out_tlast",   out_bus.tlast,  0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("release_in_tready", in_bus.tready, 0);
        @(posedge aclk);
        #1;
        check("first_edge_in_tready", in_bus.tready, 1);

        foreach (vecs[i]) begin
            @(negedge aclk);
            in_bus.tvalid  = vecs[i].vld;
            in_bus.tdata   = vecs[i].data;
            in_bus.thalf   = vecs[i].half;
            in_bus.tlast   = vecs[i].last;
            out_bus.tready = vecs[i].ordy;
            #1;
            nm = $sformatf("vec%0d", i);
            check({nm, "_in_tready"},  in_bus.tready,  vecs[i].exp_irdy);
            check({nm, "_out_tvalid"}, out_bus.tvalid, vecs[i].exp_ovld);
            if (vecs[i].exp_ovld) begin
                check({nm, "_out_tdata"}, out_bus.tdata, vecs[i].exp_odata);
                check({nm, "_out_tlast"}, out_bus.tlast, vecs[i].exp_olast);
            end
        end

        // async reset while a lower half is stalled
        @(negedge aclk);
        in_bus.tvalid  = 1'b1;
        in_bus.tdata   = "ABCDEFGHIJ";
        in_bus.thalf   = 1'b0;
        in_bus.tlast   = 1'b0;
        out_bus.tready = 1'b0;
        @(negedge aclk);
        in_bus.tvalid  = 1'b0;
        out_bus.tready = 1'b1;
        @(negedge aclk);
        out_bus.tready = 1'b0;
        #1;
        check("pre_reset_low", out_bus.tdata, "FGHIJ");
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_out_tvalid", out_bus.tvalid, 0);
        check("midrst_in_tready",  in_bus.tready,  0);
        @(negedge aclk);
        aresetn        = 1'b1;
        out_bus.tready = 1'b1;
        @(negedge aclk);
        in_bus.tvalid = 1'b1;
        in_bus.tdata  = "ABCDEFGHIJ";
        #1;
        check("postrst_out_tvalid", out_bus.tvalid, 0);
        check("postrst_in_tready",  in_bus.tready,  1);
        @(negedge aclk);
        in_bus.tvalid = 1'b0;
        #1;
        check("postrst_beat0", {out_bus.tvalid, out_bus.tdata}, {1'b1, 40'("ABCDE")});
        @(negedge aclk);
        #1;
        check("postrst_beat1", {out_bus.tvalid, out_bus.tdata}, {1'b1, 40'("FGHIJ")});
        @(negedge aclk);
        #1;
        check("postrst_idle", out_bus.tvalid, 0);

        // scoreboarded stream: 3 packets of 3 words, then a long random tail
        for (int i = 0; i < 110; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            wd.push_back(rnd[2*W-1:0]);
            wh.push_back(i >= 9 && $urandom_range(3) == 0);
            wl.push_back(i % 3 == 2);
            expq.push_back({wl[i] & wh[i], rnd[2*W-1:W]});
            if (!wh[i]) expq.push_back({wl[i], rnd[W-1:0]});
        end
        idx = 0;
        cyc = 0;
        acc = 1'b0;
        while (expq.size() > 0 && cyc < 4000) begin
            @(negedge aclk);
            if (acc) begin
                idx++;
                in_bus.tvalid = 1'b0;
            end
            if (cyc < 64)       out_bus.tready = ((cyc / 8) % 2 == 0);
            else if (cyc < 128) out_bus.tready = (cyc % 2 == 0);
            else                out_bus.tready = 1'($urandom_range(1));
            if (!in_bus.tvalid && idx < 110 && $urandom_range(2) != 0) begin
                in_bus.tvalid = 1'b1;
                in_bus.tdata  = wd[idx];
                in_bus.thalf  = wh[idx];
                in_bus.tlast  = wl[idx];
            end
            #1;
            acc = in_bus.tvalid & in_bus.tready;
            if (out_bus.tvalid && out_bus.tready) begin
                check($sformatf("stream_beat_c%0d", cyc), {out_bus.tlast, out_bus.tdata}, expq.pop_front());
            end
            cyc++;
        end
        check("stream_drained", expq.size(), 0);
        check("stream_words_taken", idx + (acc ? 1 : 0), 110);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
